// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, status bit positions and FSM encodings for uart_tx_mmio
package uart_pkg;

  // Register offsets, decoded from byte address bits [3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  // STATUS bit positions
  localparam int STAT_EMPTY    = 0;
  localparam int STAT_SHIFTING = 1;
  localparam int STAT_FULL     = 2;
  localparam int STAT_BUSY     = 3;
  localparam int STAT_OVF      = 4;

  // Transmit FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Smallest divisor the bit timer can honour
  localparam logic [15:0] MIN_DIV = 16'd2;

  // Divisor actually used for a frame: BAUDDIV clamped from below
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous show-ahead FIFO with occupancy count
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int DEFAULT_DIV = 434,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_write_data,
  input  logic        uart_wen,
  output logic [31:0] uart_read_data,
  output logic        uart_txd,
  output logic        tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    reg_sel;
  logic          wr_txdata;
  logic          ovf_set;
  logic          ovf_clr;
  logic          ovf;
  logic [15:0]   bauddiv;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [1:0]    state;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic [15:0]   baud_cnt;
  logic [15:0]   div_q;
  logic          bit_done;
  logic          shifting;
  logic          line_next;

  // Address and data bits outside the decoded fields are intentionally ignored
  logic unused_bits;
  assign unused_bits = ^{uart_addr[31:4], uart_addr[1:0], uart_write_data[31:16]};

  assign reg_sel   = uart_addr[3:2];
  assign wr_txdata = uart_wen && (reg_sel == REG_TXDATA);

  // Pop only from registered state so a byte pushed this cycle waits one cycle
  assign fifo_pop  = (state == ST_IDLE) && (fifo_count != '0);
  assign fifo_push = wr_txdata && (!fifo_full || fifo_pop);
  assign ovf_set   = wr_txdata && fifo_full && !fifo_pop;
  assign ovf_clr   = uart_wen && (reg_sel == REG_STATUS) && uart_write_data[STAT_OVF];

  assign shifting  = (state != ST_IDLE);
  assign tx_busy   = shifting || !fifo_empty;
  assign bit_done  = (baud_cnt == div_q - 16'd1);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (uart_write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Baud divisor register; frames in flight keep their own latched copy
  always_ff @(posedge clk) begin
    if (reset) begin
      bauddiv <= 16'(DEFAULT_DIV);
    end else if (uart_wen && (reg_sel == REG_BAUDDIV)) begin
      bauddiv <= uart_write_data[15:0];
    end
  end

  // Frame sequencer: every state is held for exactly div_q clocks
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      div_q    <= MIN_DIV;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (fifo_pop) begin
            state <= ST_START;
            shreg <= fifo_dout;
            div_q <= eff_div(bauddiv);
          end
        end
        ST_START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Line level implied by the current state, LSB first
  always_comb begin
    line_next = 1'b1;
    case (state)
      ST_START: line_next = 1'b0;
      ST_DATA:  line_next = shreg[0];
      default:  line_next = 1'b1;
    endcase
  end

  // Registered serial output, idle high and forced high by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_txd <= 1'b1;
    end else begin
      uart_txd <= line_next;
    end
  end

  // Combinational register read mux
  always_comb begin
    uart_read_data = '0;
    case (reg_sel)
      REG_STATUS: begin
        uart_read_data[STAT_EMPTY]    = fifo_empty;
        uart_read_data[STAT_SHIFTING] = shifting;
        uart_read_data[STAT_FULL]     = fifo_full;
        uart_read_data[STAT_BUSY]     = tx_busy;
        uart_read_data[STAT_OVF]      = ovf;
      end
      REG_BAUDDIV: uart_read_data = {16'b0, bauddiv};
      default:     uart_read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;

  localparam int DIV0  = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] uart_addr = '0;
  logic [31:0] uart_write_data = '0;
  logic        uart_wen = 1'b0;
  logic [31:0] uart_read_data;
  logic        uart_txd;
  logic        tx_busy;

  uart_tx_mmio #(
    .DEFAULT_DIV (DIV0),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .uart_addr       (uart_addr),
    .uart_write_data (uart_write_data),
    .uart_wen        (uart_wen),
    .uart_read_data  (uart_read_data),
    .uart_txd        (uart_txd),
    .tx_busy         (tx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    string       name;
  } reg_vec_t;

  frame_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Serial line monitor: pops the next expected frame on a start bit and
  // checks every sampled clock of all ten bits against the expected level.
  logic   mon_active = 1'b0;
  logic   mon_ok = 1'b1;
  logic   mon_unexp = 1'b0;
  logic   mon_lv;
  logic [7:0] mon_rx = '0;
  int     mon_s = 0;
  int     mon_b = 0;
  int     frames_seen = 0;
  frame_t mon_cur;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_txd !== 1'b1) begin
        if (exp_q.size() == 0) begin
          mon_cur.data = 8'h00;
          mon_cur.div  = DIV0;
          mon_unexp    = 1'b1;
        end else begin
          mon_cur   = exp_q.pop_front();
          mon_unexp = 1'b0;
        end
        mon_active = 1'b1;
        mon_ok     = 1'b1;
        mon_rx     = 8'h00;
        mon_s      = 1;
      end
    end else begin
      mon_b = mon_s / mon_cur.div;
      if (mon_b == 0) mon_lv = 1'b0;
      else if (mon_b == 9) mon_lv = 1'b1;
      else mon_lv = mon_cur.data[mon_b-1];
      if (uart_txd !== mon_lv) mon_ok = 1'b0;
      if (mon_b >= 1 && mon_b <= 8 && (mon_s % mon_cur.div) == mon_cur.div / 2)
        mon_rx[mon_b-1] = uart_txd;
      if (mon_s == 10 * mon_cur.div - 1) begin
        mon_active = 1'b0;
        frames_seen++;
        n_cmp++;
        if (!mon_ok || mon_unexp) begin
          n_fail++;
          $display("FAIL frame_%0d: received 0x%02h timing_ok=%0d unexpected=%0d, expected 0x%02h at %0d clocks/bit",
                   frames_seen, mon_rx, mon_ok, mon_unexp, mon_cur.data, mon_cur.div);
        end
      end else begin
        mon_s++;
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    uart_addr       = a;
    uart_write_data = d;
    uart_wen        = 1'b1;
    @(posedge clk);
    #1;
    uart_wen = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int div);
    frame_t f;
    f.data = b;
    f.div  = div;
    exp_q.push_back(f);
    bus_write(32'h0, {24'b0, b});
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    uart_addr = a;
    #1;
    chk(name, uart_read_data, exp);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((tx_busy !== 1'b0 || mon_active || exp_q.size() != 0) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL %s_idle: still busy after %0d cycles, expected idle", name, t);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  reg_vec_t vec[14];
  int       bad_line;

  initial begin
    vec[0]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h01, "status_reset"};
    vec[1]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h04, "bauddiv_reset"};
    vec[2]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h00, "txdata_read"};
    vec[3]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h00, "rsvd_read"};
    vec[4]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h00, "rsvd_write"};
    vec[5]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h04, "bauddiv_after_rsvd"};
    vec[6]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h01, "status_after_rsvd"};
    vec[7]  = '{1'b1, 32'h8000_1008, 32'hABCD_0010, 32'h00, "bauddiv_write"};
    vec[8]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h10, "bauddiv_readback"};
    vec[9]  = '{1'b0, 32'h4000_000C, 32'h0,         32'h00, "rsvd_read_high_addr"};
    vec[10] = '{1'b1, 32'h0000_0004, 32'h1F,        32'h00, "status_write"};
    vec[11] = '{1'b0, 32'h0000_0004, 32'h0,         32'h01, "status_after_write"};
    vec[12] = '{1'b1, 32'h0000_0008, 32'h4,         32'h00, "bauddiv_restore"};
    vec[13] = '{1'b0, 32'h0000_0008, 32'h0,         32'h04, "bauddiv_restored"};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("txd_reset", {31'b0, uart_txd}, 32'h1);
    chk("busy_reset", {31'b0, tx_busy}, 32'h0);

    // Register map table
    for (int i = 0; i < 14; i++) begin
      if (vec[i].wr) bus_write(vec[i].addr, vec[i].wdata);
      else read_chk(vec[i].name, vec[i].addr, vec[i].exp_rd);
    end
    @(posedge clk);
    #1;
    chk("txd_after_table", {31'b0, uart_txd}, 32'h1);
    chk("busy_after_table", {31'b0, tx_busy}, 32'h0);

    // Single byte: start bit begins after edge N+2
    send(8'h55, DIV0);
    chk("busy_after_push", {31'b0, tx_busy}, 32'h1);
    @(posedge clk);
    #1;
    chk("txd_high_at_n1", {31'b0, uart_txd}, 32'h1);
    @(posedge clk);
    #1;
    chk("txd_low_at_n2", {31'b0, uart_txd}, 32'h0);
    wait_idle("single_55");
    read_chk("status_after_55", 32'h4, 32'h01);

    // Nine back-to-back bytes all fit; the tenth overflows
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) send(8'(i), DIV0);
      else bus_write(32'h0, 32'h0A);
    end
    read_chk("status_overflow", 32'h4, 32'h1E);
    bus_write(32'h4, 32'h10);
    read_chk("status_ovf_cleared", 32'h4, 32'h0E);
    wait_idle("burst");
    read_chk("status_after_burst", 32'h4, 32'h01);

    // Divisor clamp: 1 and 0 both give 2 clocks per bit
    bus_write(32'h8, 32'h1);
    read_chk("bauddiv_one", 32'h8, 32'h1);
    send(8'hA5, 2);
    wait_idle("div1");
    bus_write(32'h8, 32'h0);
    send(8'h5A, 2);
    wait_idle("div0");
    bus_write(32'h8, DIV0);

    // Divisor change mid-frame applies only to the next frame
    send(8'h3C, DIV0);
    send(8'hC3, 8);
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    bus_write(32'h8, 32'h8);
    wait_idle("div_change");
    bus_write(32'h8, DIV0);

    // Reset mid-frame with bytes queued
    bus_write(32'h8, 32'h6);
    send(8'hA1, 6);
    send(8'hB2, 6);
    send(8'hC3, 6);
    send(8'hD4, 6);
    repeat (24) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("txd_after_reset", {31'b0, uart_txd}, 32'h1);
    reset = 1'b0;
    read_chk("status_after_reset", 32'h4, 32'h01);
    read_chk("bauddiv_after_reset", 32'h8, 32'h04);
    chk("busy_after_reset", {31'b0, tx_busy}, 32'h0);
    bad_line = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad_line++;
    end
    chk("no_frames_after_reset", 32'(bad_line), 32'h0);

    chk("frame_count", 32'(frames_seen), 32'd14);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    chk("monitor_idle", {31'b0, mon_active}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
